// File: rtl/maze_render_sched.sv
// Frame scheduler: walks enabled wall slots issuing (wall,u,v) grid points into the
// transform pipeline, counts returned valid points and flags completion once drained.
module maze_render_sched #(
  parameter int NWALL    = 5,
  parameter int GRID     = 64,
  parameter int PIPE_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [NWALL-1:0]        wall,
  input  logic                    pipe_ready,
  input  logic                    ret_en,
  output logic                    issue_valid,
  output logic [2:0]              issue_wall,
  output logic [$clog2(GRID)-1:0] issue_u,
  output logic [$clog2(GRID)-1:0] issue_v,
  output logic                    busy,
  output logic                    frame_done,
  output logic [15:0]             drawn_count
);
  localparam int UW = $clog2(GRID);
  localparam int IW = $clog2(NWALL + 1);
  localparam int LW = $clog2(PIPE_LAT + 1);
  localparam logic [UW-1:0] UMAX     = UW'(GRID - 1);
  localparam logic [IW-1:0] IDX_END  = IW'(NWALL);
  localparam logic [LW-1:0] LAT_LOAD = LW'(PIPE_LAT);

  typedef enum logic [2:0] {S_IDLE, S_SKIP, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           state_q;
  logic [NWALL-1:0] mask_q;
  logic [IW-1:0]    idx_q;
  logic [UW-1:0]    u_q, v_q;
  logic [LW-1:0]    lat_q, lat_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             fire;
  logic             wall_en;

  assign fire = (state_q == S_ISSUE) && pipe_ready;

  // idx reaches NWALL (one past the last slot), so select by compare rather than index
  always_comb begin
    wall_en = 1'b0;
    for (int i = 0; i < NWALL; i++) begin
      if (idx_q == IW'(i)) wall_en = mask_q[i];
    end
  end

  always_comb begin
    lat_d = lat_q;
    if (fire) lat_d = LAT_LOAD;
    else if (lat_q != '0) lat_d = lat_q - LW'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != S_IDLE) && ret_en && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      u_q     <= '0;
      v_q     <= '0;
      lat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      lat_q <= lat_d;
      cnt_q <= cnt_d;
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            mask_q  <= wall;
            idx_q   <= '0;
            u_q     <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
            state_q <= S_SKIP;
          end
        end
        S_SKIP: begin
          if (idx_q == IDX_END) state_q <= S_DRAIN;
          else if (wall_en)     state_q <= S_ISSUE;
          else                  idx_q   <= idx_q + IW'(1);
        end
        S_ISSUE: begin
          if (pipe_ready) begin
            if (u_q == UMAX) begin
              u_q <= '0;
              if (v_q == UMAX) begin
                v_q     <= '0;
                idx_q   <= idx_q + IW'(1);
                state_q <= S_SKIP;
              end else begin
                v_q <= v_q + UW'(1);
              end
            end else begin
              u_q <= u_q + UW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (lat_q == '0) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign issue_valid = (state_q == S_ISSUE);
  assign issue_wall  = 3'(idx_q);
  assign issue_u     = u_q;
  assign issue_v     = v_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE);
  assign drawn_count = cnt_q;

endmodule

// File: tb/tb_maze_render_sched.sv
// Directed bench for maze_render_sched with GRID=4, PIPE_LAT=4 and a return-path model.
module tb_maze_render_sched;
  localparam int NWALL = 5;
  localparam int GRID  = 4;
  localparam int L     = 4;
  localparam int UW    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame_start = 1'b0;
  logic [NWALL-1:0] wall = '0;
  logic             pipe_ready;
  logic             ret_en;
  logic             issue_valid, busy, frame_done;
  logic [2:0]       issue_wall;
  logic [UW-1:0]    issue_u, issue_v;
  logic [15:0]      drawn_count;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  logic ready_lvl    = 1'b0;
  logic ready_toggle = 1'b0;
  logic use_hist     = 1'b0;
  logic man_ret      = 1'b0;
  int   ret_sel      = -1;
  logic [L:0] hist   = '0;

  logic [6:0] pts[$];
  int         fc[$];
  int         done_cnt = 0, done_cyc = 0, stall_errs = 0, stall_seen = 0;
  logic [15:0] done_drawn = '0;
  logic       prev_stall = 1'b0;
  logic [6:0] prev_pt = '0;
  logic       fire_now, sel;

  maze_render_sched #(.NWALL(NWALL), .GRID(GRID), .PIPE_LAT(L)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .wall(wall),
    .pipe_ready(pipe_ready), .ret_en(ret_en), .issue_valid(issue_valid),
    .issue_wall(issue_wall), .issue_u(issue_u), .issue_v(issue_v), .busy(busy),
    .frame_done(frame_done), .drawn_count(drawn_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign pipe_ready = ready_toggle ? ((cyc % 3) == 0) : ready_lvl;
  // hist[L] holds the fire from L cycles back, so ret_en lands exactly PIPE_LAT after it
  assign ret_en = use_hist ? hist[L] : man_ret;

  always @(negedge clk) begin
    if (rst) begin
      hist = '0;
      prev_stall = 1'b0;
    end else begin
      fire_now = issue_valid && pipe_ready;
      sel = fire_now && ((ret_sel < 0) || (pts.size() == ret_sel));
      hist = {hist[L-1:0], sel};
      if (prev_stall && (!issue_valid || ({issue_wall, issue_v, issue_u} != prev_pt))) stall_errs++;
      if (issue_valid && !pipe_ready) stall_seen++;
      prev_stall = issue_valid && !pipe_ready;
      prev_pt = {issue_wall, issue_v, issue_u};
      if (fire_now) begin
        pts.push_back({issue_wall, issue_v, issue_u});
        fc.push_back(cyc);
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        done_drawn = drawn_count;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic clear_log();
    pts.delete();
    fc.delete();
    done_cnt = 0;
    stall_errs = 0;
    stall_seen = 0;
  endtask

  task automatic run_until_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      sample();
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step(); sample();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", issue_valid); end
    checks++; if ({issue_wall, issue_v, issue_u} !== 7'd0) begin fails++; $display("FAIL rst_fields got %h want 0", {issue_wall, issue_v, issue_u}); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", frame_done); end
    checks++; if (drawn_count !== 16'd0) begin fails++; $display("FAIL rst_count got %0d want 0", drawn_count); end
    step();
    rst = 1'b0; wall = 5'b00001; ready_lvl = 1'b1; use_hist = 1'b1; ret_sel = -1; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (6) step();
    sample();
    // fires at start+2..start+6 -> u=1,v=1; first return counted by now
    checks++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL midframe_valid got %b want 1", issue_valid); end
    checks++; if ({issue_v, issue_u} !== 4'b0101) begin fails++; $display("FAIL midframe_vu got %b want 0101", {issue_v, issue_u}); end
    checks++; if (drawn_count !== 16'd1) begin fails++; $display("FAIL midframe_count got %0d want 1", drawn_count); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; use_hist = 1'b0; man_ret = 1'b1;
    sample();
    checks++; if (busy !== 1'b0 || issue_valid !== 1'b0) begin fails++; $display("FAIL abort_state got busy=%b valid=%b want 0 0", busy, issue_valid); end
    checks++; if ({issue_wall, issue_v, issue_u} !== 7'd0) begin fails++; $display("FAIL abort_fields got %h want 0", {issue_wall, issue_v, issue_u}); end
    step();
    man_ret = 1'b0;
    sample();
    checks++; if (drawn_count !== 16'd0) begin fails++; $display("FAIL abort_ret_ignored got %0d want 0", drawn_count); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin fails++; $display("FAIL abort_idle got busy=%b done=%b want 0 0", busy, frame_done); end
    step();
  endtask

  task automatic test_basic();
    int  t;
    bit  ok;
    logic [6:0] exp_pt;
    clear_log();
    wall = 5'b00101; ready_lvl = 1'b1; use_hist = 1'b1; ret_sel = -1;
    frame_start = 1'b1; t = cyc;
    step();
    frame_start = 1'b0;
    sample();
    checks++; if (busy !== 1'b1 || issue_valid !== 1'b0) begin fails++; $display("FAIL basic_t1 got busy=%b valid=%b want 1 0", busy, issue_valid); end
    step(); sample();
    checks++; if (issue_valid !== 1'b1 || {issue_wall, issue_v, issue_u} !== 7'd0) begin fails++; $display("FAIL basic_t2 got valid=%b pt=%h want 1 00", issue_valid, {issue_wall, issue_v, issue_u}); end
    run_until_done(300, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL basic_timeout got no frame_done want done within 300"); end
    checks++; if (drawn_count !== 16'd32) begin fails++; $display("FAIL basic_count got %0d want 32", drawn_count); end
    checks++; if (pts.size() !== 32) begin fails++; $display("FAIL basic_issues got %0d want 32", pts.size()); end
    for (int i = 0; i < 32 && i < pts.size(); i++) begin
      exp_pt = {(i < 16) ? 3'd0 : 3'd2, 2'((i % 16) / 4), 2'(i % 4)};
      checks++; if (pts[i] !== exp_pt) begin fails++; $display("FAIL basic_order[%0d] got %h want %h", i, pts[i], exp_pt); end
    end
    if (pts.size() == 32) begin
      checks++; if (fc[0] - t !== 2) begin fails++; $display("FAIL basic_first_lat got %0d want 2", fc[0] - t); end
      checks++; if (fc[15] - fc[0] !== 15) begin fails++; $display("FAIL basic_b2b got %0d want 15", fc[15] - fc[0]); end
      checks++; if (fc[16] - fc[15] !== 3) begin fails++; $display("FAIL basic_wall_gap got %0d want 3", fc[16] - fc[15]); end
      checks++; if (done_cyc - fc[31] !== 6) begin fails++; $display("FAIL basic_done_lat got %0d want 6", done_cyc - fc[31]); end
    end
    step(); sample();
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin fails++; $display("FAIL basic_after got busy=%b done=%b want 0 0", busy, frame_done); end
    checks++; if (drawn_count !== 16'd32) begin fails++; $display("FAIL basic_hold got %0d want 32", drawn_count); end
    step();
  endtask

  task automatic test_stall();
    bit ok;
    logic [6:0] exp_pt;
    clear_log();
    wall = 5'b00101; ready_toggle = 1'b1; use_hist = 1'b1; ret_sel = -1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    run_until_done(500, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL stall_timeout got no frame_done want done within 500"); end
    checks++; if (stall_errs !== 0) begin fails++; $display("FAIL stall_stable got %0d changes want 0", stall_errs); end
    checks++; if (stall_seen < 20) begin fails++; $display("FAIL stall_seen got %0d want >=20", stall_seen); end
    checks++; if (pts.size() !== 32) begin fails++; $display("FAIL stall_issues got %0d want 32", pts.size()); end
    for (int i = 0; i < 32 && i < pts.size(); i++) begin
      exp_pt = {(i < 16) ? 3'd0 : 3'd2, 2'((i % 16) / 4), 2'(i % 4)};
      checks++; if (pts[i] !== exp_pt) begin fails++; $display("FAIL stall_order[%0d] got %h want %h", i, pts[i], exp_pt); end
    end
    checks++; if (drawn_count !== 16'd32) begin fails++; $display("FAIL stall_count got %0d want 32", drawn_count); end
    step();
    ready_toggle = 1'b0;
    step();
  endtask

  task automatic test_zero_mask();
    int t;
    bit ok;
    clear_log();
    wall = 5'b00000; ready_lvl = 1'b1; use_hist = 1'b1;
    frame_start = 1'b1; t = cyc;
    step();
    frame_start = 1'b0;
    run_until_done(50, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL zero_timeout got no frame_done want done within 50"); end
    checks++; if (done_cyc - t !== NWALL + 3) begin fails++; $display("FAIL zero_latency got %0d want %0d", done_cyc - t, NWALL + 3); end
    checks++; if (pts.size() !== 0) begin fails++; $display("FAIL zero_issues got %0d want 0", pts.size()); end
    checks++; if (drawn_count !== 16'd0) begin fails++; $display("FAIL zero_count got %0d want 0", drawn_count); end
    step();
  endtask

  task automatic test_restart_ignored();
    bit ok;
    int bad;
    clear_log();
    wall = 5'b00001; ready_lvl = 1'b1; use_hist = 1'b1; ret_sel = -1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0; wall = 5'b00000;
    repeat (4) step();
    frame_start = 1'b1; wall = 5'b11111;
    step();
    frame_start = 1'b0; wall = 5'b00000;
    run_until_done(200, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL restart_timeout got no frame_done want done within 200"); end
    checks++; if (done_drawn !== 16'd16) begin fails++; $display("FAIL restart_count got %0d want 16", done_drawn); end
    repeat (20) step();
    sample();
    bad = 0;
    foreach (pts[i]) if (pts[i][6:4] != 3'd0) bad++;
    checks++; if (pts.size() !== 16) begin fails++; $display("FAIL restart_issues got %0d want 16", pts.size()); end
    checks++; if (bad !== 0) begin fails++; $display("FAIL restart_walls got %0d foreign points want 0", bad); end
    checks++; if (done_cnt !== 1) begin fails++; $display("FAIL restart_done_pulses got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL restart_idle got busy=%b want 0", busy); end
    step();
  endtask

  task automatic test_drain_boundary();
    bit ok;
    clear_log();
    wall = 5'b00001; ready_lvl = 1'b1; use_hist = 1'b1; ret_sel = 15;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    run_until_done(200, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL drain_timeout got no frame_done want done within 200"); end
    checks++; if (drawn_count !== 16'd1) begin fails++; $display("FAIL drain_count got %0d want 1", drawn_count); end
    if (fc.size() == 16) begin
      checks++; if (done_cyc - fc[15] !== 7) begin fails++; $display("FAIL drain_done_lat got %0d want 7", done_cyc - fc[15]); end
    end
    step();
    ret_sel = -1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_mask();
    test_restart_ignored();
    test_drain_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/maze_render_sched.md
# maze_render_sched

Frame-level scheduler for the wall-point rendering datapath. On a frame start it walks every enabled wall slot and issues each (wall, u, v) grid point into the transform pipeline. It respects a ready/stall signal from the pipeline and counts the valid points returned by the `check_valid` stage. After the last in-flight point has drained it reports frame completion. It sits between the frame/VGA control logic and the coordinate-transform pipeline head.

## Interface
Parameters:
- `NWALL`, 5 — number of wall slots; width of the `wall` mask.
- `GRID`, 64 — points per wall edge (power of two, ≥2); each enabled wall issues GRID×GRID points.
- `PIPE_LAT`, 4 — cycles from an issue handshake to the matching `ret_en` from `check_valid` (≥1).

Ports:
- `clk` input 1 — single clock; all logic on posedge.
- `rst` input 1 — synchronous, active-high reset.
- `frame_start` input 1 — one-cycle request to render a frame; honoured only in IDLE.
- `wall` input NWALL — wall-enable mask; sampled on an accepted `frame_start`.
- `pipe_ready` input 1 — pipeline accepts an issue this cycle.
- `ret_en` input 1 — `en` output of `check_valid`; one valid drawn point.
- `issue_valid` output 1 — the point on `issue_*` is presented.
- `issue_wall` output 3 — wall index of the presented point.
- `issue_u` output log2(GRID) — inner (fast) grid coordinate.
- `issue_v` output log2(GRID) — outer (slow) grid coordinate.
- `busy` output 1 — high in every state except IDLE.
- `frame_done` output 1 — one-cycle pulse when the frame is complete.
- `drawn_count` output 16 — number of `ret_en` pulses counted in the current/last frame.

## Operation
- States: IDLE, SKIP, ISSUE, DRAIN, DONE.
- IDLE, on `frame_start`:
  - latch `wall` into `mask_q`; set `idx`, `u`, `v` and `drawn_count` to 0;
  - go to SKIP.
- SKIP, one cycle per evaluation:
  - `idx == NWALL` → DRAIN;
  - else `mask_q[idx]` → ISSUE;
  - else `idx` += 1 and stay in SKIP.
- ISSUE:
  - `issue_valid` = 1 (combinational from state); `issue_wall`/`issue_u`/`issue_v` come from the `idx`/`u`/`v` registers.
  - Fire is `issue_valid & pipe_ready`. With `pipe_ready` = 0, all fields are held stable.
  - On fire: `u` += 1.
  - When `u == GRID-1`: `u` ← 0 and `v` += 1.
  - When `u` and `v` are both `GRID-1`: `u` ← 0, `v` ← 0, `idx` += 1, go to SKIP.
- Latency counter `lat`:
  - loaded with `PIPE_LAT` on every fire;
  - otherwise decrements while nonzero.
- DRAIN: stay while `lat != 0`; go to DONE when `lat == 0`.
- DONE: `frame_done` = 1 for exactly this cycle, then IDLE.
- `drawn_count`:
  - increments on `ret_en` in every non-IDLE state;
  - saturates at 16'hFFFF;
  - holds its value in IDLE until the next accepted `frame_start`.
- `ret_en` in IDLE is ignored.
- `frame_start` outside IDLE is ignored and does not restart the frame.
- All-zero mask: IDLE → SKIP (NWALL+1 cycles, `idx` 0..NWALL) → DRAIN (`lat` = 0, one cycle) → DONE. `drawn_count` stays 0.
- Reset mid-frame aborts immediately:
  - in-flight points are forgotten;
  - `ret_en` arriving after reset is not counted.

## Timing
- Reset values:
  - state IDLE, `busy` 0, `issue_valid` 0, `issue_wall`/`issue_u`/`issue_v` 0;
  - `frame_done` 0, `drawn_count` 0, `lat` 0, `mask_q` 0.
- Accepted `frame_start` at cycle t:
  - `busy` = 1 from t+1;
  - if `wall[0]` = 1, the first `issue_valid` is at t+2.
- Each SKIP over a disabled wall costs 1 cycle. Each wall-to-wall transition costs at least 1 SKIP cycle.
- With `pipe_ready` held 1, a wall issues GRID×GRID points on consecutive cycles.
- Last fire at cycle T with `PIPE_LAT` = L:
  - last `ret_en` expected at T+L and counted;
  - `frame_done` no earlier than T+L+1;
  - `busy` drops the cycle after `frame_done`.
- `drawn_count` is final in the cycle `frame_done` is high.

## Test plan
- Reset mid-ISSUE (GRID=4, `wall`=5'b00001), then release → all outputs at reset values, state IDLE; a `ret_en` pulse after reset leaves `drawn_count` = 0.
- GRID=4, L=4, `wall`=5'b00101, `pipe_ready`=1, `ret_en` pulsed for every issue L cycles later:
  - order is wall 0 u0..3 for v0..3, then wall 2;
  - 32 issues in total;
  - `drawn_count`=32 at `frame_done`.
- Same setup with `pipe_ready` toggling 1,0,0,1… → fields stable during stalls; 32 fires; no point skipped or duplicated.
- `wall`=0 → `frame_done` exactly NWALL+3 cycles after `frame_start` (t+NWALL+3); zero issues; `drawn_count`=0.
- `frame_start` pulsed while busy → ignored; frame completes with the original mask and one `frame_done`.
- Drain boundary: `ret_en` only on the cycle exactly L after the final fire → `drawn_count`=1 at `frame_done`.
